// File: rtl/fetch_bpu.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// The lookup is combinational on the current PC; training from Execute lands on the next clock edge.
module fetch_bpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ENTRIES  = 16,
    parameter int          IDX_W    = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPCE,
    input  logic        UpdateE,
    input  logic [31:0] UpdPCE,
    input  logic        UpdTakenE,
    input  logic [31:0] UpdTargetE,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        TakenF,
    output logic [31:0] imem_addr
);

    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]                    r_pc;
    logic [ENTRIES-1:0]             w_valid_vec;
    logic [ENTRIES-1:0][TAG_W-1:0]  w_tag_vec;
    logic [ENTRIES-1:0][31:0]       w_target_vec;
    logic [ENTRIES-1:0][1:0]        w_ctr_vec;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_taken;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_pred_pc;
    logic [31:0]      w_pc_next;

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_unused_pc_lsbs;

    // Byte-offset bits never take part in index or tag.
    assign w_unused_pc_lsbs = &{1'b0, UpdPCE[1:0]};

    // Prediction path
    assign w_idx      = r_pc[IDX_W+1:2];
    assign w_tag      = r_pc[31:IDX_W+2];
    assign w_hit      = w_valid_vec[w_idx] && (w_tag_vec[w_idx] == w_tag);
    assign w_taken    = w_hit && w_ctr_vec[w_idx][1];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pred_pc  = w_taken ? w_target_vec[w_idx] : w_pc_plus4;

    // A redirect from Execute wins over a stall so a mispredict is never lost.
    assign w_pc_next = RedirectE ? RedirectPCE :
                       StallF    ? r_pc        : w_pred_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign PCF       = r_pc;
    assign imem_addr = r_pc;
    assign PCPlus4F  = w_pc_plus4;
    assign TakenF    = w_taken;

    // Training path
    assign w_upd_idx = UpdPCE[IDX_W+1:2];
    assign w_upd_tag = UpdPCE[31:IDX_W+2];
    assign w_upd_hit = w_valid_vec[w_upd_idx] && (w_tag_vec[w_upd_idx] == w_upd_tag);

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        logic [31:0]      r_target;
        logic [1:0]       r_ctr;
        logic             w_sel;

        assign w_sel = UpdateE && (w_upd_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_valid <= 1'b0;
            end else if (w_sel && !w_upd_hit && UpdTakenE) begin
                r_valid <= 1'b1;
            end
        end

        // Payload needs no reset: it is ignored while the entry is invalid.
        always_ff @(posedge clk) begin
            if (w_sel) begin
                if (w_upd_hit) begin
                    if (UpdTakenE) begin
                        r_target <= UpdTargetE;
                        if (r_ctr != 2'b11) begin
                            r_ctr <= r_ctr + 2'd1;
                        end
                    end else if (r_ctr != 2'b00) begin
                        r_ctr <= r_ctr - 2'd1;
                    end
                end else if (UpdTakenE) begin
                    r_tag    <= w_upd_tag;
                    r_target <= UpdTargetE;
                    r_ctr    <= 2'b10;
                end
            end
        end

        assign w_valid_vec[gi]  = r_valid;
        assign w_tag_vec[gi]    = r_tag;
        assign w_target_vec[gi] = r_target;
        assign w_ctr_vec[gi]    = r_ctr;
    end

endmodule

// File: tb/tb_fetch_bpu.sv
// Bench for fetch_bpu: directed scenarios plus a randomized run checked against
// a table-of-branches model of the predictor kept at the PC-arithmetic level.
module tb_fetch_bpu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ENTRIES  = 16;
    localparam int          IDX_W    = $clog2(ENTRIES);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallF = 1'b0;
    logic        RedirectE = 1'b0;
    logic [31:0] RedirectPCE = '0;
    logic        UpdateE = 1'b0;
    logic [31:0] UpdPCE = '0;
    logic        UpdTakenE = 1'b0;
    logic [31:0] UpdTargetE = '0;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        TakenF;
    logic [31:0] imem_addr;

    int checks = 0;
    int errors = 0;

    // Model: each slot remembers the full PC of the branch that owns it.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_owner  [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_pc;

    fetch_bpu #(.RESET_PC(RESET_PC), .ENTRIES(ENTRIES)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .RedirectE  (RedirectE),
        .RedirectPCE(RedirectPCE),
        .UpdateE    (UpdateE),
        .UpdPCE     (UpdPCE),
        .UpdTakenE  (UpdTakenE),
        .UpdTargetE (UpdTargetE),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .TakenF     (TakenF),
        .imem_addr  (imem_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int s;
        s = slot(pc);
        return m_valid[s] && ((m_owner[s] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    function automatic bit model_taken(input logic [31:0] pc);
        return model_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC;
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
    task automatic step(input bit stall, input bit redir, input logic [31:0] rpc,
                        input bit upd, input logic [31:0] upc, input bit utk,
                        input logic [31:0] utgt);
        logic [31:0] nxt;
        int s;
        StallF = stall; RedirectE = redir; RedirectPCE = rpc;
        UpdateE = upd; UpdPCE = upc; UpdTakenE = utk; UpdTargetE = utgt;
        @(posedge clk);
        if (redir)       nxt = rpc;
        else if (stall)  nxt = m_pc;
        else             nxt = model_taken(m_pc) ? m_target[slot(m_pc)] : m_pc + 32'd4;
        if (upd) begin
            s = slot(upc);
            if (model_hit(upc)) begin
                if (utk) begin
                    m_ctr[s]    = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                    m_target[s] = utgt;
                end else begin
                    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (utk) begin
                m_valid[s] = 1'b1; m_owner[s] = upc; m_target[s] = utgt; m_ctr[s] = 2;
            end
        end
        m_pc = nxt;
        #1;
        StallF = 1'b0; RedirectE = 1'b0; UpdateE = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train_stalled(input logic [31:0] upc, input bit utk, input logic [31:0] utgt);
        step(1'b1, 1'b0, 32'h0, 1'b1, upc, utk, utgt);
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (PCF !== RESET_PC || TakenF !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: PCF=%h TakenF=%b, required PCF=%h TakenF=0", PCF, TakenF, RESET_PC);
        end
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'(k * 4);
            checks++;
            if (PCF !== exp_pc || TakenF !== 1'b0 || imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL seq_fetch: PCF=%h imem=%h TakenF=%b, required %h/%h/0", PCF, imem_addr, TakenF, exp_pc, exp_pc);
            end else $display("seq_fetch PCF=%h TakenF=%b", PCF, TakenF);
            if (k < 3) idle();
        end
    endtask

    task automatic test_stall();
        redirect(32'h08);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if (PCF !== 32'h08) begin
                errors++;
                $display("FAIL stall_hold: PCF=%h, required 00000008", PCF);
            end else $display("stall_hold PCF=%h", PCF);
        end
        step(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (PCF !== 32'h80) begin
            errors++;
            $display("FAIL redirect_over_stall: PCF=%h, required 00000080", PCF);
        end else $display("redirect_over_stall PCF=%h", PCF);
    endtask

    task automatic test_train();
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h40);
        checks++;
        if (PCF !== 32'h10 || TakenF !== 1'b1) begin
            errors++;
            $display("FAIL train_alloc: PCF=%h TakenF=%b, required 00000010/1", PCF, TakenF);
        end else $display("train_alloc PCF=%h TakenF=%b", PCF, TakenF);
        idle();
        checks++;
        if (PCF !== 32'h40) begin
            errors++;
            $display("FAIL predicted_target: PCF=%h, required 00000040", PCF);
        end else $display("predicted_target PCF=%h", PCF);
    endtask

    task automatic test_counter();
        train_stalled(32'h10, 1'b0, 32'h0);
        train_stalled(32'h10, 1'b0, 32'h0);
        redirect(32'h10);
        checks++;
        if (TakenF !== 1'b0) begin
            errors++;
            $display("FAIL ctr_down: TakenF=%b, required 0", TakenF);
        end else $display("ctr_down PCF=%h TakenF=%b", PCF, TakenF);
        idle();
        checks++;
        if (PCF !== 32'h14) begin
            errors++;
            $display("FAIL not_taken_fallthrough: PCF=%h, required 00000014", PCF);
        end else $display("not_taken_fallthrough PCF=%h", PCF);
        // Four taken updates from 00 must saturate at 11, so one decrement still predicts taken.
        for (int k = 0; k < 4; k++) train_stalled(32'h10, 1'b1, 32'h40);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 32'h0);
        checks++;
        if (TakenF !== 1'b1) begin
            errors++;
            $display("FAIL ctr_saturate: TakenF=%b, required 1", TakenF);
        end else $display("ctr_saturate PCF=%h TakenF=%b", PCF, TakenF);
        // Update and lookup on the same slot: this cycle still predicts with the old counter.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        checks++;
        if (PCF !== 32'h40) begin
            errors++;
            $display("FAIL same_cycle_lookup: PCF=%h, required 00000040", PCF);
        end else $display("same_cycle_lookup PCF=%h", PCF);
        redirect(32'h10);
        checks++;
        if (TakenF !== 1'b0) begin
            errors++;
            $display("FAIL ctr_weak_nt: TakenF=%b, required 0", TakenF);
        end else $display("ctr_weak_nt PCF=%h TakenF=%b", PCF, TakenF);
    endtask

    task automatic test_alias();
        train_stalled(32'h10, 1'b1, 32'h40);
        redirect(32'h50);
        checks++;
        if (TakenF !== 1'b0) begin
            errors++;
            $display("FAIL alias_tag_miss: TakenF=%b, required 0", TakenF);
        end else $display("alias_tag_miss PCF=%h TakenF=%b", PCF, TakenF);
        train_stalled(32'h50, 1'b1, 32'h200);
        checks++;
        if (TakenF !== 1'b1) begin
            errors++;
            $display("FAIL alias_alloc: TakenF=%b, required 1", TakenF);
        end else $display("alias_alloc PCF=%h TakenF=%b", PCF, TakenF);
        redirect(32'h10);
        checks++;
        if (TakenF !== 1'b0) begin
            errors++;
            $display("FAIL alias_evict: TakenF=%b, required 0", TakenF);
        end else $display("alias_evict PCF=%h TakenF=%b", PCF, TakenF);
        idle();
        checks++;
        if (PCF !== 32'h14) begin
            errors++;
            $display("FAIL alias_fallthrough: PCF=%h, required 00000014", PCF);
        end else $display("alias_fallthrough PCF=%h", PCF);
    endtask

    task automatic test_reset_mid();
        train_stalled(32'h10, 1'b1, 32'h40);
        redirect(32'h10);
        checks++;
        if (TakenF !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_trained: TakenF=%b, required 1", TakenF);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (PCF !== RESET_PC || TakenF !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: PCF=%h TakenF=%b, required %h/0", PCF, TakenF, RESET_PC);
        end else $display("async_reset PCF=%h TakenF=%b", PCF, TakenF);
        @(posedge clk);
        #3 rst = 1'b1;
        redirect(32'h10);
        checks++;
        if (PCF !== 32'h10 || TakenF !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_btb: PCF=%h TakenF=%b, required 00000010/0", PCF, TakenF);
        end else $display("reset_clears_btb PCF=%h TakenF=%b", PCF, TakenF);
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFC);
        checks++;
        if (PCPlus4F !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap_plus4: PCPlus4F=%h, required 00000000", PCPlus4F);
        end else $display("pc_wrap PCF=%h PCPlus4F=%h", PCF, PCPlus4F);
        idle();
        checks++;
        if (PCF !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap_next: PCF=%h, required 00000000", PCF);
        end else $display("pc_wrap_next PCF=%h", PCF);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 1) * 64 + $urandom_range(0, 1) * 32'h1000);
    endfunction

    task automatic test_random();
        bit stall, redir, upd, utk;
        for (int n = 0; n < 300; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            redir = ($urandom_range(0, 9) == 0) || (m_pc > 32'h2000);
            upd   = ($urandom_range(0, 1) == 1);
            utk   = ($urandom_range(0, 2) != 0);
            step(stall, redir, rand_pc(), upd, rand_pc(), utk, rand_pc());
            checks++;
            if (PCF !== m_pc || imem_addr !== m_pc || PCPlus4F !== m_pc + 32'd4 ||
                TakenF !== model_taken(m_pc)) begin
                errors++;
                $display("FAIL random_%0d: PCF=%h PCPlus4F=%h TakenF=%b, required %h/%h/%b",
                         n, PCF, PCPlus4F, TakenF, m_pc, m_pc + 32'd4, model_taken(m_pc));
            end else $display("random_%0d PCF=%h TakenF=%b", n, PCF, TakenF);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_train();
        test_counter();
        test_alias();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
